// File: rtl/mc_control_fsm.sv
// mc_control_fsm
//   Multi-cycle control unit for the 16-bit lime processor. Decodes
//   {funct, opcode} from the instruction register and steps the datapath
//   through fetch / decode / execute / memory / writeback. Memory accesses
//   stall on a mem_req / mem_ready handshake. Illegal encodings halt the unit
//   in TRAP until Reset.
//
//   Optional build macro: CTRL_TIMEOUT_EN
//     Adds a memory watchdog. After MEM_TIMEOUT consecutive wait cycles the
//     unit traps with cause 2'b10. Without the macro no counter is built and
//     waits are unbounded.
//
// Ports
//   CLK                       in   clock, rising edge
//   Reset                     in   asynchronous active-high reset
//   input_control             in   {funct, opcode}
//   mem_ready                 in   memory completed the current request
//   mem_req                   out  memory access in progress
//   output_control_*          out  datapath strobes, mux selects, ALU op
//   trap                      out  unit halted in TRAP
//   trap_cause                out  00 none, 01 illegal encoding, 10 timeout
//   state_out                 out  current state encoding (debug)

module mc_control_fsm #(
    parameter int OP_W        = 3,
    parameter int FUNCT_W     = 4,
    parameter int ALUOP_W     = 4,
    parameter int LINK_OP     = 7,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic [OP_W+FUNCT_W-1:0]   input_control,
    input  logic                      mem_ready,
    output logic                      mem_req,
    output logic                      output_control_branch,
    output logic                      output_control_IoD,
    output logic                      output_control_IRWrite,
    output logic                      output_control_Mem2Reg,
    output logic                      output_control_MemR,
    output logic                      output_control_MemW,
    output logic                      output_control_PCSrc,
    output logic                      output_control_PCWrite,
    output logic                      output_control_RegWrite,
    output logic [1:0]                output_control_ALUSrcA,
    output logic [1:0]                output_control_ALUSrcB,
    output logic [1:0]                output_control_branchType,
    output logic [ALUOP_W-1:0]        output_control_ALUOp,
    output logic                      trap,
    output logic [1:0]                trap_cause,
    output logic [3:0]                state_out
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_RTYPE3    = 4'd2;
    localparam logic [3:0] S_RITYPE    = 4'd3;
    localparam logic [3:0] S_RTYPE_END = 4'd4;
    localparam logic [3:0] S_LW1       = 4'd5;
    localparam logic [3:0] S_LW2       = 4'd6;
    localparam logic [3:0] S_SW        = 4'd7;
    localparam logic [3:0] S_JALR      = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_BRANCH2   = 4'd10;
    localparam logic [3:0] S_JAL       = 4'd11;
    localparam logic [3:0] S_TRAP      = 4'd15;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    logic [3:0]         state, state_next;
    logic [1:0]         cause_q, cause_next;
    logic [OP_W-1:0]    opcode;
    logic [FUNCT_W-1:0] funct;
    logic               wait_state;
    logic               waiting;
    logic               timeout;

    assign opcode = input_control[OP_W-1:0];
    assign funct  = input_control[OP_W+FUNCT_W-1:OP_W];

    // States that hold a memory request open and stall on mem_ready.
    assign wait_state = (state == S_FETCH) || (state == S_LW1) || (state == S_SW);
    assign waiting    = wait_state && !mem_ready;

`ifdef CTRL_TIMEOUT_EN
    localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Counts consecutive stalled cycles; the edge that would bring the count
    // to MEM_TIMEOUT is the one that enters TRAP, and the counter clears then.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)
            wait_cnt <= '0;
        else if (waiting && !timeout)
            wait_cnt <= wait_cnt + CNT_W'(1);
        else
            wait_cnt <= '0;
    end

    assign timeout = waiting && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
`else
    // MEM_TIMEOUT only matters when the watchdog is built.
    logic [31:0] unused_mem_timeout;
    assign unused_mem_timeout = 32'(MEM_TIMEOUT);
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state   <= S_FETCH;
            cause_q <= 2'b00;
        end else begin
            state   <= state_next;
            cause_q <= cause_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        cause_next = cause_q;
        case (state)
            S_FETCH: begin
                if (mem_ready)
                    state_next = S_DECODE;
                else if (timeout) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_W'(0): state_next = S_RTYPE3;
                    OP_W'(1): begin
                        if (funct == FUNCT_W'(4'b1011))
                            state_next = S_JALR;
                        else if ((funct & FUNCT_W'(4'b1100)) == FUNCT_W'(4'b1100))
                            state_next = S_BRANCH;
                        else
                            state_next = S_RITYPE;
                    end
                    OP_W'(2): state_next = S_RITYPE;
                    OP_W'(3): state_next = S_FETCH;
                    OP_W'(4): state_next = S_JAL;
                    default: begin
                        state_next = S_TRAP;
                        cause_next = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_RTYPE3: begin
                if (funct > FUNCT_W'(4'b1000)) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_ILLEGAL;
                end else begin
                    state_next = S_RTYPE_END;
                end
            end
            S_RITYPE: begin
                if (funct == FUNCT_W'(4'b1001))
                    state_next = S_LW1;
                else if (funct == FUNCT_W'(4'b1010))
                    state_next = S_SW;
                else
                    state_next = S_RTYPE_END;
            end
            S_RTYPE_END: state_next = S_FETCH;
            S_LW1: begin
                if (mem_ready)
                    state_next = S_LW2;
                else if (timeout) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_LW2: state_next = S_FETCH;
            S_SW: begin
                if (mem_ready)
                    state_next = S_FETCH;
                else if (timeout) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_JALR:    state_next = S_FETCH;
            S_JAL:     state_next = S_FETCH;
            S_BRANCH:  state_next = S_BRANCH2;
            S_BRANCH2: state_next = S_FETCH;
            S_TRAP:    state_next = S_TRAP;
            // Unused encodings recover to FETCH.
            default:   state_next = S_FETCH;
        endcase
    end

    // Output logic (Moore, except FETCH qualifying IR/PC writes on mem_ready)
    always_comb begin
        mem_req                   = 1'b0;
        output_control_branch     = 1'b0;
        output_control_IoD        = 1'b0;
        output_control_IRWrite    = 1'b0;
        output_control_Mem2Reg    = 1'b0;
        output_control_MemR       = 1'b0;
        output_control_MemW       = 1'b0;
        output_control_PCSrc      = 1'b0;
        output_control_PCWrite    = 1'b0;
        output_control_RegWrite   = 1'b0;
        output_control_ALUSrcA    = 2'd0;
        output_control_ALUSrcB    = 2'd0;
        output_control_branchType = 2'd0;
        output_control_ALUOp      = '1;
        case (state)
            S_FETCH: begin
                mem_req                = 1'b1;
                output_control_MemR    = 1'b1;
                output_control_ALUOp   = '0;
                output_control_ALUSrcB = 2'd1;
                output_control_IRWrite = mem_ready;
                output_control_PCWrite = mem_ready;
            end
            S_RTYPE3: begin
                output_control_ALUOp   = ALUOP_W'(funct);
                output_control_ALUSrcA = 2'd2;
            end
            S_RITYPE: begin
                output_control_ALUOp   = ALUOP_W'(funct);
                output_control_ALUSrcA = 2'd2;
                output_control_ALUSrcB = 2'd2;
            end
            S_RTYPE_END: output_control_RegWrite = 1'b1;
            S_LW1: begin
                mem_req             = 1'b1;
                output_control_IoD  = 1'b1;
                output_control_MemR = 1'b1;
            end
            S_LW2: begin
                output_control_RegWrite = 1'b1;
                output_control_Mem2Reg  = 1'b1;
            end
            S_SW: begin
                mem_req             = 1'b1;
                output_control_IoD  = 1'b1;
                output_control_MemW = 1'b1;
            end
            S_JALR, S_JAL: begin
                output_control_ALUOp    = ALUOP_W'(LINK_OP);
                output_control_ALUSrcA  = 2'd3;
                output_control_ALUSrcB  = 2'd1;
                output_control_RegWrite = 1'b1;
                output_control_PCSrc    = 1'b1;
                output_control_PCWrite  = 1'b1;
            end
            S_BRANCH: begin
                output_control_ALUOp      = '0;
                output_control_ALUSrcB    = 2'd2;
                output_control_branch     = 1'b1;
                output_control_branchType = funct[1:0];
            end
            S_BRANCH2: begin
                output_control_ALUOp      = ALUOP_W'(1);
                output_control_ALUSrcA    = 2'd2;
                output_control_branch     = 1'b1;
                output_control_branchType = funct[1:0];
                output_control_PCSrc      = 1'b1;
                output_control_PCWrite    = 1'b1;
            end
            default: ;
        endcase
        // While held in reset the state reads FETCH, but no fetch may start.
        if (Reset) begin
            mem_req                = 1'b0;
            output_control_MemR    = 1'b0;
            output_control_IRWrite = 1'b0;
            output_control_PCWrite = 1'b0;
        end
    end

    assign trap       = (state == S_TRAP);
    assign trap_cause = cause_q;
    assign state_out  = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic [6:0] input_control = '0;
    logic       mem_ready = 1'b1;
    logic       mem_req, br, iod, irw, m2r, memr, memw, pcsrc, pcw, rw;
    logic [1:0] srca, srcb, btype;
    logic [3:0] aluop;
    logic       trap;
    logic [1:0] trap_cause;
    logic [3:0] state_out;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mc_control_fsm #(.MEM_TIMEOUT(4)) dut (
        .CLK(CLK), .Reset(Reset), .input_control(input_control), .mem_ready(mem_ready),
        .mem_req(mem_req),
        .output_control_branch(br), .output_control_IoD(iod), .output_control_IRWrite(irw),
        .output_control_Mem2Reg(m2r), .output_control_MemR(memr), .output_control_MemW(memw),
        .output_control_PCSrc(pcsrc), .output_control_PCWrite(pcw), .output_control_RegWrite(rw),
        .output_control_ALUSrcA(srca), .output_control_ALUSrcB(srcb),
        .output_control_branchType(btype), .output_control_ALUOp(aluop),
        .trap(trap), .trap_cause(trap_cause), .state_out(state_out)
    );

    // Strobe order: {mem_req, branch, IoD, IRWrite, Mem2Reg, MemR, MemW, PCSrc, PCWrite, RegWrite}
    localparam logic [9:0] S_NONE  = 10'b0000000000;
    localparam logic [9:0] S_FETCH = 10'b1001010010;
    localparam logic [9:0] S_FWAIT = 10'b1000010000;
    localparam logic [9:0] S_RW    = 10'b0000000001;
    localparam logic [9:0] S_LW1   = 10'b1010010000;
    localparam logic [9:0] S_LW2   = 10'b0000100001;
    localparam logic [9:0] S_SW    = 10'b1010001000;
    localparam logic [9:0] S_JMP   = 10'b0000000111;
    localparam logic [9:0] S_BR    = 10'b0100000000;
    localparam logic [9:0] S_BR2   = 10'b0100000110;

    // {funct, opcode}
    localparam logic [6:0] ADD  = 7'b0000_000;
    localparam logic [6:0] R8   = 7'b1000_000;
    localparam logic [6:0] ILL  = 7'b1001_000;
    localparam logic [6:0] LW   = 7'b1001_010;
    localparam logic [6:0] SW   = 7'b1010_010;
    localparam logic [6:0] RIA  = 7'b0011_010;
    localparam logic [6:0] JAL  = 7'b0000_100;
    localparam logic [6:0] JALR = 7'b1011_001;
    localparam logic [6:0] BR   = 7'b1110_001;
    localparam logic [6:0] NOP  = 7'b0000_011;
    localparam logic [6:0] OP6  = 7'b0000_110;

    typedef struct {
        logic       rst;
        logic [6:0] ic;
        logic       rdy;
        logic [3:0] st;
        logic [9:0] stb;
        logic [1:0] a, b, bt;
        logic [3:0] alu;
        logic       tr;
        logic [1:0] cause;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [6:0] ic, input logic rdy,
                       input logic [3:0] st, input logic [9:0] stb,
                       input logic [1:0] a, input logic [1:0] b, input logic [1:0] bt,
                       input logic [3:0] alu, input logic tr, input logic [1:0] cause);
        vec_t v;
        v.rst = r; v.ic = ic; v.rdy = rdy; v.st = st; v.stb = stb;
        v.a = a; v.b = b; v.bt = bt; v.alu = alu; v.tr = tr; v.cause = cause;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] observe();
        return {5'd0, state_out, mem_req, br, iod, irw, m2r, memr, memw, pcsrc, pcw, rw,
                srca, srcb, btype, aluop, trap, trap_cause};
    endfunction

    initial begin
        // Reset held for three cycles: FETCH values with fetch strobes blocked.
        repeat (3) add(1, ADD, 1, 0, S_NONE, 0, 1, 0, 4'h0, 0, 0);
        // add: 0,1,2,4
        add(0, ADD, 1, 0, S_FETCH, 0, 1, 0, 4'h0, 0, 0);
        add(0, ADD, 0, 1, S_NONE,  0, 0, 0, 4'hF, 0, 0);
        add(0, ADD, 1, 2, S_NONE,  2, 0, 0, 4'h0, 0, 0);
        add(0, ADD, 1, 4, S_RW,    0, 0, 0, 4'hF, 0, 0);
        // lw with two stalled cycles in LW1
        add(0, LW, 1, 0, S_FETCH, 0, 1, 0, 4'h0, 0, 0);
        add(0, LW, 1, 1, S_NONE,  0, 0, 0, 4'hF, 0, 0);
        add(0, LW, 1, 3, S_NONE,  2, 2, 0, 4'h9, 0, 0);
        add(0, LW, 0, 5, S_LW1,   0, 0, 0, 4'hF, 0, 0);
        add(0, LW, 0, 5, S_LW1,   0, 0, 0, 4'hF, 0, 0);
        add(0, LW, 1, 5, S_LW1,   0, 0, 0, 4'hF, 0, 0);
        add(0, LW, 1, 6, S_LW2,   0, 0, 0, 4'hF, 0, 0);
        // fetch stall, then sw with one stalled cycle
        add(0, SW, 0, 0, S_FWAIT, 0, 1, 0, 4'h0, 0, 0);
        add(0, SW, 0, 0, S_FWAIT, 0, 1, 0, 4'h0, 0, 0);
        add(0, SW, 1, 0, S_FETCH, 0, 1, 0, 4'h0, 0, 0);
        add(0, SW, 1, 1, S_NONE,  0, 0, 0, 4'hF, 0, 0);
        add(0, SW, 1, 3, S_NONE,  2, 2, 0, 4'hA, 0, 0);
        add(0, SW, 0, 7, S_SW,    0, 0, 0, 4'hF, 0, 0);
        add(0, SW, 1, 7, S_SW,    0, 0, 0, 4'hF, 0, 0);
        // jal
        add(0, JAL, 1, 0,  S_FETCH, 0, 1, 0, 4'h0, 0, 0);
        add(0, JAL, 1, 1,  S_NONE,  0, 0, 0, 4'hF, 0, 0);
        add(0, JAL, 0, 11, S_JMP,   3, 1, 0, 4'h7, 0, 0);
        // jalr
        add(0, JALR, 1, 0, S_FETCH, 0, 1, 0, 4'h0, 0, 0);
        add(0, JALR, 1, 1, S_NONE,  0, 0, 0, 4'hF, 0, 0);
        add(0, JALR, 1, 8, S_JMP,   3, 1, 0, 4'h7, 0, 0);
        // branch, funct 1110 -> branchType 10
        add(0, BR, 1, 0,  S_FETCH, 0, 1, 0, 4'h0, 0, 0);
        add(0, BR, 1, 1,  S_NONE,  0, 0, 0, 4'hF, 0, 0);
        add(0, BR, 0, 9,  S_BR,    0, 2, 2, 4'h0, 0, 0);
        add(0, BR, 1, 10, S_BR2,   2, 0, 2, 4'h1, 0, 0);
        // no-op returns to FETCH after DECODE
        add(0, NOP, 1, 0, S_FETCH, 0, 1, 0, 4'h0, 0, 0);
        add(0, NOP, 0, 1, S_NONE,  0, 0, 0, 4'hF, 0, 0);
        // RI-ALU, funct 0011
        add(0, RIA, 1, 0, S_FETCH, 0, 1, 0, 4'h0, 0, 0);
        add(0, RIA, 1, 1, S_NONE,  0, 0, 0, 4'hF, 0, 0);
        add(0, RIA, 1, 3, S_NONE,  2, 2, 0, 4'h3, 0, 0);
        add(0, RIA, 1, 4, S_RW,    0, 0, 0, 4'hF, 0, 0);
        // R-type with funct 1001 is illegal -> TRAP cause 01
        add(0, ILL, 1, 0,  S_FETCH, 0, 1, 0, 4'h0, 0, 0);
        add(0, ILL, 1, 1,  S_NONE,  0, 0, 0, 4'hF, 0, 0);
        add(0, ILL, 1, 2,  S_NONE,  2, 0, 0, 4'h9, 0, 0);
        add(0, ILL, 1, 15, S_NONE,  0, 0, 0, 4'hF, 1, 1);
        add(0, ILL, 0, 15, S_NONE,  0, 0, 0, 4'hF, 1, 1);
        add(1, ADD, 1, 0,  S_NONE,  0, 1, 0, 4'h0, 0, 0);
        // R-type funct 1000 is the largest legal code
        add(0, R8, 1, 0, S_FETCH, 0, 1, 0, 4'h0, 0, 0);
        add(0, R8, 1, 1, S_NONE,  0, 0, 0, 4'hF, 0, 0);
        add(0, R8, 1, 2, S_NONE,  2, 0, 0, 4'h8, 0, 0);
        add(0, R8, 1, 4, S_RW,    0, 0, 0, 4'hF, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge CLK);
            Reset = tbl[i].rst;
            input_control = tbl[i].ic;
            mem_ready = tbl[i].rdy;
            #1;
            chk($sformatf("vec%0d", i), observe(),
                {5'd0, tbl[i].st, tbl[i].stb, tbl[i].a, tbl[i].b, tbl[i].bt,
                 tbl[i].alu, tbl[i].tr, tbl[i].cause});
        end

        // Opcode 110 traps; trap persists; Reset leaves TRAP asynchronously.
        @(negedge CLK); Reset = 1'b1;
        @(negedge CLK); Reset = 1'b0; input_control = OP6; mem_ready = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK); #1;
        chk("op6_trap", {28'd0, state_out}, 32'd15);
        chk("op6_cause", {29'd0, trap, trap_cause}, {29'd0, 1'b1, 2'b01});
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK); mem_ready = k[0]; #1;
            chk($sformatf("trap_hold%0d", k), {25'd0, state_out, trap, trap_cause},
                {25'd0, 4'd15, 1'b1, 2'b01});
        end
        #2 Reset = 1'b1; #1;
        chk("trap_reset", {25'd0, state_out, trap, trap_cause}, 32'd0);

        // Memory stall in FETCH with mem_ready held low.
        @(negedge CLK); Reset = 1'b0; mem_ready = 1'b0; input_control = ADD;
        repeat (3) @(posedge CLK);
        @(negedge CLK); #1;
        chk("stall3", {27'd0, state_out, irw}, 32'd0);
`ifdef CTRL_TIMEOUT_EN
        @(posedge CLK); @(negedge CLK); #1;
        chk("timeout_trap", {25'd0, state_out, trap, trap_cause}, {25'd0, 4'd15, 1'b1, 2'b10});
`else
        repeat (20) @(posedge CLK);
        @(negedge CLK); #1;
        chk("no_timeout", {25'd0, state_out, trap, trap_cause}, 32'd0);
        chk("no_timeout_req", {30'd0, mem_req, irw}, {30'd0, 1'b1, 1'b0});
`endif

        // Reset asserted mid-SW aborts without waiting for a clock edge.
        @(negedge CLK); Reset = 1'b1;
        @(negedge CLK); Reset = 1'b0; mem_ready = 1'b1; input_control = SW;
        repeat (3) @(posedge CLK);
        @(negedge CLK); mem_ready = 1'b0; #1;
        chk("sw_state", {27'd0, state_out, memw}, {27'd0, 4'd7, 1'b1});
        #2 Reset = 1'b1; #1;
        chk("sw_abort", {24'd0, state_out, memw, mem_req, pcw, rw}, 32'd0);
        @(negedge CLK); Reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
